// File: rtl/obj_scheduler_if.sv
// Spawn request/response handshake between the game logic and obj_scheduler.
interface obj_scheduler_if;
    logic       spawn_req;
    logic [1:0] spawn_type;
    logic [9:0] spawn_vpos;
    logic       spawn_ack;
    logic       spawn_drop;

    modport master (
        output spawn_req,
        output spawn_type,
        output spawn_vpos,
        input  spawn_ack,
        input  spawn_drop
    );

    modport slave (
        input  spawn_req,
        input  spawn_type,
        input  spawn_vpos,
        output spawn_ack,
        output spawn_drop
    );
endinterface

// File: rtl/obj_scheduler.sv
// Per-frame sequencer for the five object records shown by display.
// Once per frame, on the falling edge of vsync, it scrolls, retires and
// animates each slot, places at most one pending spawn, and commits all
// five records together so display never sees a half-updated set.
module obj_scheduler #(
    parameter int unsigned SPAWN_HPOS     = 1023,
    parameter int unsigned SPAWN_COOLDOWN = 30,
    parameter int unsigned ANIM_DIV       = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic [10:0]           d_offset,
    obj_scheduler_if.slave        spawn,
    output logic                  busy,
    output logic [2:0]            active_count,
    output logic [25:0]           obj1,
    output logic [25:0]           obj2,
    output logic [25:0]           obj3,
    output logic [25:0]           obj4,
    output logic [25:0]           obj5
);

    localparam int unsigned NSLOT = 5;
    localparam int unsigned FC_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int unsigned CD_W  = (SPAWN_COOLDOWN > 0) ? $clog2(SPAWN_COOLDOWN + 1) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN0  = 3'd1,
        SCAN1  = 3'd2,
        SCAN2  = 3'd3,
        SCAN3  = 3'd4,
        SCAN4  = 3'd5,
        SPAWN  = 3'd6,
        COMMIT = 3'd7
    } state_t;

    state_t            state;
    state_t            state_n;

    logic              vsync_d;
    logic              frame_start;

    logic              load_w;
    logic              scan_en;
    logic [2:0]        scan_idx;
    logic              spawn_dec;
    logic              commit_en;

    logic [25:0]       w     [NSLOT];
    logic [25:0]       obj_q [NSLOT];

    logic [FC_W-1:0]   fc;
    logic              anim_step;
    logic [CD_W-1:0]   cooldown;
    logic              cd_loaded;

    logic              pending;
    logic [1:0]        p_type;
    logic [9:0]        p_vpos;

    logic [25:0]       scan_cur;
    logic [25:0]       scan_res;
    logic              has_free;
    logic [2:0]        free_idx;
    logic              spawn_go;
    logic              spawn_place;
    logic [25:0]       new_rec;
    logic [2:0]        cnt;

    assign frame_start = vsync_d & ~vsync;
    assign anim_step   = (ANIM_DIV == 1) || (fc == '0);
    assign new_rec     = {3'b000, p_type, 11'(SPAWN_HPOS), p_vpos};
    assign spawn_go    = spawn_dec && pending && (cooldown == '0);
    assign spawn_place = spawn_go && (p_type != 2'b00) && has_free;

    assign obj1 = obj_q[0];
    assign obj2 = obj_q[1];
    assign obj3 = obj_q[2];
    assign obj4 = obj_q[3];
    assign obj5 = obj_q[4];

    // Delay vsync by one cycle to detect its falling edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vsync_d <= 1'b0;
        end else begin
            vsync_d <= vsync;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and per-state strobes; one cycle per state.
    always_comb begin
        state_n   = state;
        load_w    = 1'b0;
        scan_en   = 1'b0;
        scan_idx  = 3'd0;
        spawn_dec = 1'b0;
        commit_en = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    load_w  = 1'b1;
                    state_n = SCAN0;
                end
            end
            SCAN0: begin
                scan_en  = 1'b1;
                scan_idx = 3'd0;
                state_n  = SCAN1;
            end
            SCAN1: begin
                scan_en  = 1'b1;
                scan_idx = 3'd1;
                state_n  = SCAN2;
            end
            SCAN2: begin
                scan_en  = 1'b1;
                scan_idx = 3'd2;
                state_n  = SCAN3;
            end
            SCAN3: begin
                scan_en  = 1'b1;
                scan_idx = 3'd3;
                state_n  = SCAN4;
            end
            SCAN4: begin
                scan_en  = 1'b1;
                scan_idx = 3'd4;
                state_n  = SPAWN;
            end
            SPAWN: begin
                spawn_dec = 1'b1;
                state_n   = COMMIT;
            end
            COMMIT: begin
                commit_en = 1'b1;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Scroll one slot: retire if it would pass the left edge, else move and animate.
    always_comb begin
        scan_cur = w[scan_idx];
        scan_res = scan_cur;
        if (scan_cur[22:21] != 2'b00) begin
            if (d_offset > scan_cur[20:10]) begin
                scan_res = '0;
            end else begin
                scan_res[20:10] = 11'(scan_cur[20:10] - d_offset);
                if (anim_step) begin
                    scan_res[25:23] = 3'(scan_cur[25:23] + 3'd1);
                end
            end
        end
    end

    // Lowest-index empty slot and occupancy count of the working set.
    always_comb begin
        has_free = 1'b0;
        free_idx = 3'd0;
        cnt      = 3'd0;
        for (int unsigned k = 0; k < NSLOT; k++) begin
            if (!has_free && (w[k][22:21] == 2'b00)) begin
                has_free = 1'b1;
                free_idx = 3'(k);
            end
            cnt = 3'(cnt + 3'(w[k][22:21] != 2'b00));
        end
    end

    // Working copies: load on frame start, update during scan and spawn.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NSLOT; k++) begin
                w[k] <= '0;
            end
        end else if (load_w) begin
            for (int unsigned k = 0; k < NSLOT; k++) begin
                w[k] <= obj_q[k];
            end
        end else if (scan_en) begin
            w[scan_idx] <= scan_res;
        end else if (spawn_place) begin
            w[free_idx] <= new_rec;
        end
    end

    // Visible records and count change only at commit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NSLOT; k++) begin
                obj_q[k] <= '0;
            end
            active_count <= 3'd0;
        end else if (commit_en) begin
            for (int unsigned k = 0; k < NSLOT; k++) begin
                obj_q[k] <= w[k];
            end
            active_count <= cnt;
        end
    end

    // Animation frame counter, free-running modulo ANIM_DIV per committed frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fc <= '0;
        end else if (commit_en) begin
            fc <= FC_W'(fc + 1'b1);
        end
    end

    // Latch the newest request; a request in the decision cycle carries to the next frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            p_type  <= 2'b00;
            p_vpos  <= 10'd0;
        end else if (spawn.spawn_req) begin
            pending <= 1'b1;
            p_type  <= spawn.spawn_type;
            p_vpos  <= spawn.spawn_vpos;
        end else if (spawn_go) begin
            pending <= 1'b0;
        end
    end

    // Cooldown: loaded on placement, counted down at each later commit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cooldown  <= '0;
            cd_loaded <= 1'b0;
        end else if (spawn_place) begin
            cooldown  <= CD_W'(SPAWN_COOLDOWN);
            cd_loaded <= 1'b1;
        end else if (commit_en) begin
            if (cd_loaded) begin
                cd_loaded <= 1'b0;
            end else if (cooldown != '0) begin
                cooldown <= CD_W'(cooldown - 1'b1);
            end
        end
    end

    // Registered status: one-cycle ack/drop pulses and busy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            spawn.spawn_ack  <= 1'b0;
            spawn.spawn_drop <= 1'b0;
            busy             <= 1'b0;
        end else begin
            spawn.spawn_ack  <= spawn_place;
            spawn.spawn_drop <= spawn_go && !spawn_place;
            busy             <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_obj_scheduler.sv
// Self-checking bench for obj_scheduler: directed scenarios plus random frames
// against a slot-level behavioural model.
`timescale 1ns/1ps
module tb_obj_scheduler;

    localparam int unsigned SPAWN_HPOS     = 1023;
    localparam int unsigned SPAWN_COOLDOWN = 30;
    localparam int unsigned ANIM_DIV       = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b0;
    logic [10:0] d_offset = 11'd0;
    logic        busy;
    logic [2:0]  active_count;
    logic [25:0] obj1, obj2, obj3, obj4, obj5;

    obj_scheduler_if sif ();

    obj_scheduler #(
        .SPAWN_HPOS     (SPAWN_HPOS),
        .SPAWN_COOLDOWN (SPAWN_COOLDOWN),
        .ANIM_DIV       (ANIM_DIV)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .vsync        (vsync),
        .d_offset     (d_offset),
        .spawn        (sif),
        .busy         (busy),
        .active_count (active_count),
        .obj1         (obj1),
        .obj2         (obj2),
        .obj3         (obj3),
        .obj4         (obj4),
        .obj5         (obj5)
    );

    always #7.692 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: one entry per slot, fields kept as plain integers.
    int m_typ [5];
    int m_anim[5];
    int m_hpos[5];
    int m_vpos[5];
    int m_pending, m_ptype, m_pvpos, m_cd, m_fc;

    int obs_ack, obs_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] m_rec(input int i);
        return 26'(m_anim[i] * (1 << 23) + m_typ[i] * (1 << 21) + m_hpos[i] * (1 << 10) + m_vpos[i]);
    endfunction

    function automatic logic [25:0] dut_obj(input int i);
        case (i)
            0: return obj1;
            1: return obj2;
            2: return obj3;
            3: return obj4;
            default: return obj5;
        endcase
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 5; i++) if (m_typ[i] != 0) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_typ[i] = 0; m_anim[i] = 0; m_hpos[i] = 0; m_vpos[i] = 0;
        end
        m_pending = 0; m_ptype = 0; m_pvpos = 0; m_cd = 0; m_fc = 0;
    endtask

    // One frame of the scheduler's rules, applied to the model.
    task automatic model_frame(input int d, output int e_ack, output int e_drop);
        int free;
        int loaded;
        bit step;
        step   = (m_fc % ANIM_DIV) == 0;
        e_ack  = 0;
        e_drop = 0;
        loaded = 0;
        for (int i = 0; i < 5; i++) begin
            if (m_typ[i] != 0) begin
                if (d > m_hpos[i]) begin
                    m_typ[i] = 0; m_anim[i] = 0; m_hpos[i] = 0; m_vpos[i] = 0;
                end else begin
                    m_hpos[i] = m_hpos[i] - d;
                    if (step) m_anim[i] = (m_anim[i] + 1) % 8;
                end
            end
        end
        if (m_pending != 0 && m_cd == 0) begin
            free = -1;
            for (int i = 0; i < 5; i++) if (m_typ[i] == 0 && free < 0) free = i;
            if (m_ptype == 0 || free < 0) begin
                e_drop = 1;
            end else begin
                m_typ[free] = m_ptype; m_anim[free] = 0;
                m_hpos[free] = SPAWN_HPOS; m_vpos[free] = m_pvpos;
                e_ack  = 1;
                m_cd   = SPAWN_COOLDOWN;
                loaded = 1;
            end
            m_pending = 0;
        end
        if (m_cd > 0 && loaded == 0) m_cd--;
        m_fc++;
    endtask

    task automatic request(input int t, input int v);
        @(negedge clock);
        sif.spawn_req  = 1'b1;
        sif.spawn_type = 2'(t);
        sif.spawn_vpos = 10'(v);
        @(negedge clock);
        sif.spawn_req  = 1'b0;
        m_pending = 1; m_ptype = t; m_pvpos = v;
    endtask

    // Pulse vsync; the next posedge is E0.
    task automatic start_frame(input int d);
        @(negedge clock);
        d_offset = 11'(d);
        vsync    = 1'b1;
        @(negedge clock);
        @(negedge clock);
        vsync    = 1'b0;
    endtask

    task automatic do_frame(input int d);
        logic [25:0] old[5];
        int ea, ed;
        bit hold;
        start_frame(d);
        for (int i = 0; i < 5; i++) old[i] = m_rec(i);
        model_frame(d, ea, ed);
        for (int e = 0; e <= 7; e++) begin
            @(posedge clock);
            #1;
            if (e == 3) check("busy_mid", 32'(busy), 32'd1);
            if (e == 6) begin
                obs_ack  = int'(sif.spawn_ack);
                obs_drop = int'(sif.spawn_drop);
                check("ack_e6", 32'(sif.spawn_ack), 32'(ea));
                check("drop_e6", 32'(sif.spawn_drop), 32'(ed));
                hold = 1'b1;
                for (int i = 0; i < 5; i++) if (dut_obj(i) !== old[i]) hold = 1'b0;
                check("hold_e6", 32'(hold), 32'd1);
            end
            if (e == 7) begin
                for (int i = 0; i < 5; i++)
                    check($sformatf("obj%0d", i + 1), 32'(dut_obj(i)), 32'(m_rec(i)));
                check("count", 32'(active_count), 32'(m_count()));
                check("pulse_e7", 32'({sif.spawn_ack, sif.spawn_drop}), 32'd0);
            end
        end
        repeat (2) @(posedge clock);
        #1;
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic hard_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic run_until_ack(input int t, input int v, output int waited, output int drops);
        request(t, v);
        waited = 0;
        drops  = 0;
        do_frame(0);
        drops += obs_drop;
        while (obs_ack == 0 && waited < 40) begin
            waited++;
            do_frame(0);
            drops += obs_drop;
        end
        if (obs_ack == 0) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_cooldown();
        int n = 0;
        while (m_cd != 0 && n < 40) begin
            do_frame(0);
            n++;
        end
    endtask

    initial begin
        int waited, drops, ea, ed;
        logic [25:0] snap[5];
        bit same;
        sif.spawn_req  = 1'b0;
        sif.spawn_type = 2'b00;
        sif.spawn_vpos = 10'd0;
        model_reset();
        #3 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 5; i++) check("rst_obj", 32'(dut_obj(i)), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(active_count), 32'd0);
        check("rst_pulse", 32'({sif.spawn_ack, sif.spawn_drop}), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Single spawn, then a second request held by cooldown.
        request(2, 384);
        do_frame(1);
        check("spawn_ack", 32'(obs_ack), 32'd1);
        check("spawn_rec", 32'(obj1), 32'({3'b000, 2'd2, 11'd1023, 10'd384}));
        request(1, 100);
        do_frame(1);
        check("hpos_1022", 32'(obj1[20:10]), 32'd1022);
        waited = (obs_ack == 0) ? 1 : 0;
        drops  = obs_drop;
        while (obs_ack == 0 && waited < 40) begin
            do_frame(1);
            drops += obs_drop;
            if (obs_ack == 0) waited++;
        end
        check("cd_wait", 32'(waited), 32'(SPAWN_COOLDOWN));
        check("cd_nodrop", 32'(drops), 32'd0);

        // Retirement at hpos 3 with offset 5; survival at hpos 5 with offset 5.
        do_frame(m_hpos[0] - 3);
        check("hpos_3", 32'(obj1[20:10]), 32'd3);
        check("count_2", 32'(active_count), 32'd2);
        do_frame(5);
        check("retired", 32'(obj1), 32'd0);
        check("count_dec", 32'(active_count), 32'd1);
        do_frame(m_hpos[1] - 5);
        do_frame(5);
        check("edge_hpos0", 32'(obj2[20:10]), 32'd0);
        check("edge_alive", 32'(obj2[22:21]), 32'd1);

        // Type 0 request is dropped.
        wait_cooldown();
        request(0, 5);
        do_frame(0);
        check("type0_drop", 32'(obs_drop), 32'd1);
        check("type0_noack", 32'(obs_ack), 32'd0);

        // Reset mid-SCAN2 with an object present.
        start_frame(3);
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) check("midrst_obj", 32'(dut_obj(i)), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(active_count), 32'd0);
        check("midrst_pulse", 32'({sif.spawn_ack, sif.spawn_drop}), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        request(3, 200);
        do_frame(2);
        check("postrst_ack", 32'(obs_ack), 32'd1);
        check("postrst_rec", 32'(obj1), 32'({3'b000, 2'd3, 11'd1023, 10'd200}));

        // Full slots: drop, then a retirement in slot 3 makes room there.
        hard_reset();
        run_until_ack(1, 10, waited, drops);
        run_until_ack(2, 20, waited, drops);
        do_frame(1000);
        run_until_ack(3, 30, waited, drops);
        do_frame(30);
        for (int k = 0; k < 4; k++) run_until_ack(1, 40 + k, waited, drops);
        check("full_count", 32'(active_count), 32'd5);
        wait_cooldown();
        for (int i = 0; i < 5; i++) snap[i] = dut_obj(i);
        request(1, 50);
        do_frame(0);
        check("full_drop", 32'(obs_drop), 32'd1);
        same = 1'b1;
        for (int i = 0; i < 5; i++) if (dut_obj(i) !== snap[i]) same = 1'b0;
        check("full_same", 32'(same), 32'd1);
        request(2, 77);
        do_frame(1000);
        check("slot3_ack", 32'(obs_ack), 32'd1);
        check("slot3_rec", 32'(obj3), 32'({3'b000, 2'd2, 11'd1023, 10'd77}));

        // Animation: two steps in 16 frames, then wrap 7 -> 0.
        hard_reset();
        request(1, 300);
        do_frame(0);
        repeat (16) do_frame(0);
        check("anim_2", 32'(obj1[25:23]), 32'd2);
        repeat (40) do_frame(0);
        check("anim_7", 32'(obj1[25:23]), 32'd7);
        repeat (8) do_frame(0);
        check("anim_wrap", 32'(obj1[25:23]), 32'd0);

        // Random frames against the model.
        hard_reset();
        for (int n = 0; n < 150; n++) begin
            int d;
            if ($urandom_range(0, 1) == 1) request(int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)));
            if ($urandom_range(0, 4) == 0) request(int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)));
            if ($urandom_range(0, 7) == 0) d = int'($urandom_range(0, 2047));
            else d = int'($urandom_range(0, 47));
            do_frame(d);
        end
        ea = 0; ed = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
